// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Looked up by fetch with one-cycle latency, trained by branch resolution from execute.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 64,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lkp_valid,
  input  logic [31:0] lkp_pc,
  input  logic        flush,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam int unsigned TGT_W = 30;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic [1:0]       cnt;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  btb_entry_t       mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  btb_entry_t rd_entry;
  btb_entry_t upd_cur;
  btb_entry_t wr_entry;
  logic       wr_en;
  logic       set_valid;
  logic       upd_hit;
  logic       lkp_go;
  logic       lkp_hit;
  logic       lkp_taken;

  // Word-aligned PCs: the low two bits never reach the index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lkp_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign lkp_idx = lkp_pc[IDX_W+1:2];
  assign lkp_tag = lkp_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup read path; storage is sampled before this edge's training write lands.
  always_comb begin
    rd_entry  = mem[lkp_idx];
    lkp_go    = lkp_valid && !flush;
    lkp_hit   = valid_q[lkp_idx] && (rd_entry.tag == lkp_tag);
    lkp_taken = lkp_hit && rd_entry.cnt[1];
  end

  // Training decision for the resolved branch.
  always_comb begin
    upd_cur   = mem[upd_idx];
    wr_entry  = upd_cur;
    wr_en     = 1'b0;
    set_valid = 1'b0;
    upd_hit   = valid_q[upd_idx] && (upd_cur.tag == upd_tag);
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_entry.cnt    = sat_inc(upd_cur.cnt);
          wr_entry.target = upd_target[31:2];
        end else begin
          wr_entry.cnt    = sat_dec(upd_cur.cnt);
        end
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        set_valid       = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = upd_target[31:2];
        wr_entry.cnt    = CNT_INIT;
      end
    end
  end

  // Entry payload is gated by its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[upd_idx] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Response register; a flush only kills the lookup being issued this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
    end else begin
      pred_valid <= lkp_go;
      pred_hit   <= lkp_go && lkp_hit;
      pred_taken <= lkp_go && lkp_taken;
      pred_pc    <= (lkp_go && lkp_taken) ? {rd_entry.target, 2'b00} : 32'h0;
    end
  end

endmodule
